// File: rtl/mem_router.sv
// mem_router: single-master to NSLV-slave memory bus router.
// Window decode, optional rebase, one outstanding txn, error on miss/timeout.
module mem_router #(
    parameter int unsigned         NSLV       = 5,
    parameter logic [NSLV*32-1:0]  SLV_BASE   = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0]  SLV_TOP    = {NSLV{32'h0}},
    parameter logic [NSLV-1:0]     SLV_REBASE = {NSLV{1'b1}},
    parameter int unsigned         TIMEOUT    = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_rdata,
    output logic                 mem_ready,
    output logic                 mem_error,
    output logic [NSLV-1:0]      slv_valid,
    output logic                 slv_instr,
    output logic [31:0]          slv_addr,
    output logic [31:0]          slv_wdata,
    output logic [3:0]           slv_wstrb,
    input  logic [NSLV*32-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ready,
    output logic [15:0]          err_count
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR
    } state_t;

    state_t          state;
    logic [SW-1:0]   sel;
    logic [31:0]     tcnt;
    logic [15:0]     err_cnt;

    logic            hit;
    logic [NSLV-1:0] hit_oh;
    logic [SW-1:0]   hit_idx;
    logic [31:0]     hit_addr;

    logic            sel_ready;
    logic [31:0]     sel_rdata;
    logic            tmo;

    // Window decode: offset < size covers base<=addr<top; lowest index wins.
    always_comb begin
        hit      = 1'b0;
        hit_oh   = '0;
        hit_idx  = '0;
        hit_addr = mem_addr;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if ((SLV_BASE[32*k +: 32] < SLV_TOP[32*k +: 32]) &&
                ((mem_addr - SLV_BASE[32*k +: 32]) <
                 (SLV_TOP[32*k +: 32] - SLV_BASE[32*k +: 32]))) begin
                hit      = 1'b1;
                hit_oh   = '0;
                hit_oh[k] = 1'b1;
                hit_idx  = SW'(k);
                hit_addr = SLV_REBASE[k] ?
                           (mem_addr - SLV_BASE[32*k +: 32]) : mem_addr;
            end
        end
    end

    assign sel_ready = slv_ready[sel];
    assign sel_rdata = slv_rdata[32*32'(sel) +: 32];
    assign tmo       = (TIMEOUT != 0) && ((tcnt + 32'd1) == TIMEOUT);

    // Completion path is combinational so ready reaches the core same cycle.
    always_comb begin
        mem_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = '0;
        if (state == S_ERR) begin
            mem_ready = 1'b1;
            mem_error = 1'b1;
        end else if (state == S_WAIT) begin
            if (sel_ready) begin
                mem_ready = 1'b1;
                mem_rdata = sel_rdata;
            end else if (tmo) begin
                mem_ready = 1'b1;
                mem_error = 1'b1;
            end
        end
    end

    // Request FSM: latch decoded payload, pulse slave strobe, await response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            sel       <= '0;
            tcnt      <= '0;
            slv_valid <= '0;
            slv_instr <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_wstrb <= '0;
        end else begin
            tcnt <= '0;
            unique case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        if (hit) begin
                            sel       <= hit_idx;
                            slv_valid <= hit_oh;
                            slv_instr <= mem_instr;
                            slv_addr  <= hit_addr;
                            slv_wdata <= mem_wdata;
                            slv_wstrb <= mem_wstrb;
                            state     <= S_REQ;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_REQ: begin
                    slv_valid <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (sel_ready || tmo) begin
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating tally of error completions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (mem_ready && mem_error && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_count = err_cnt;

endmodule
